// File: rtl/counter_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : counter_seq_pkg
//  Brief    : Shared state encodings and default widths for the counter
//             sequencer slice.
//  Revision : 1.0  initial release
// ============================================================================
package counter_seq_pkg;

    localparam int DEF_CNT_W  = 16;
    localparam int DEF_STEP_W = 5;
    localparam int DEF_LAP_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_UP   = 3'd2,
        ST_DOWN = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/counter_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : counter_sequencer_if
//  Brief    : Control, limit and counter-pin bundle of the counter sequencer.
//             master = sequencer side, slave = switch logic / counter side.
//  Revision : 1.0  initial release
// ============================================================================
interface counter_sequencer_if
    import counter_seq_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int STEP_W = DEF_STEP_W,
    parameter int LAP_W  = DEF_LAP_W
);
    logic              start;
    logic              abort;
    logic              hold;
    logic [STEP_W-1:0] step_in;
    logic [CNT_W-1:0]  upper_lim;
    logic [CNT_W-1:0]  lower_lim;
    logic [CNT_W-1:0]  count_value;
    logic              cnt_enable;
    logic              cnt_clear_n;
    logic              cnt_dir;
    logic [STEP_W-1:0] cnt_step;
    logic              cnt_disp;
    logic              busy;
    logic              done;
    logic              err;
    logic [LAP_W-1:0]  laps;

    modport master (
        input  start, abort, hold, step_in, upper_lim, lower_lim, count_value,
        output cnt_enable, cnt_clear_n, cnt_dir, cnt_step, cnt_disp,
               busy, done, err, laps
    );

    modport slave (
        output start, abort, hold, step_in, upper_lim, lower_lim, count_value,
        input  cnt_enable, cnt_clear_n, cnt_dir, cnt_step, cnt_disp,
               busy, done, err, laps
    );
endinterface
`default_nettype wire

// File: rtl/seq_limit_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : seq_limit_cmp
//  Brief    : Lookahead limit compares. Evaluated one bit wider than the
//             counter so value+step and lower+step can never wrap.
//  Revision : 1.0  initial release
// ============================================================================
module seq_limit_cmp
    import counter_seq_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int STEP_W = DEF_STEP_W
) (
    input  wire logic [CNT_W-1:0]  count_value,
    input  wire logic [STEP_W-1:0] step,
    input  wire logic [CNT_W-1:0]  upper,
    input  wire logic [CNT_W-1:0]  lower,
    output logic                   up_ok,
    output logic                   dn_ok
);
    logic [CNT_W:0] step_ext;
    logic [CNT_W:0] up_sum;
    logic [CNT_W:0] dn_floor;

    assign step_ext = {{(CNT_W + 1 - STEP_W){1'b0}}, step};
    assign up_sum   = {1'b0, count_value} + step_ext;
    assign dn_floor = {1'b0, lower} + step_ext;

    // Another step up stays at or under upper; another step down stays at or over lower.
    always_comb begin
        up_ok = (up_sum <= {1'b0, upper});
        dn_ok = ({1'b0, count_value} >= dn_floor);
    end
endmodule
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : counter_sequencer
//  Brief    : Drives an up/down step counter through clear, count-up to an
//             upper limit, count-down to a lower limit, then done.
//             Optional macro AUTO_RELOAD_EN: DOWN loops back to UP and
//             completed laps are counted until abort.
//  Revision : 1.0  initial release
// ============================================================================
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int STEP_W = DEF_STEP_W,
    parameter int LAP_W  = DEF_LAP_W
) (
    input  wire logic         clock,
    input  wire logic         reset,
    counter_sequencer_if.master bus
);
    state_t            state;
    logic [STEP_W-1:0] step_lat;
    logic [CNT_W-1:0]  upper_lat;
    logic [CNT_W-1:0]  lower_lat;
    logic              err_flag;
    logic              up_ok;
    logic              dn_ok;
    logic              busy;

    seq_limit_cmp #(
        .CNT_W  (CNT_W),
        .STEP_W (STEP_W)
    ) u_cmp (
        .count_value (bus.count_value),
        .step        (step_lat),
        .upper       (upper_lat),
        .lower       (lower_lat),
        .up_ok       (up_ok),
        .dn_ok       (dn_ok)
    );

`ifdef AUTO_RELOAD_EN
    logic [LAP_W-1:0] lap_cnt;

    // Lap counter: cleared on each new sequence, bumped on every DOWN->UP reload.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lap_cnt <= '0;
        end else if (!bus.abort) begin
            if (state == ST_CLR) begin
                lap_cnt <= '0;
            end else if (state == ST_DOWN && !dn_ok) begin
                lap_cnt <= lap_cnt + LAP_W'(1);
            end
        end
    end

    assign bus.laps = lap_cnt;
`else
    assign bus.laps = {LAP_W{1'b0}};
`endif

    // Sequencer FSM plus the step/limit latches and sticky error flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            step_lat  <= '0;
            upper_lat <= '0;
            lower_lat <= '0;
            err_flag  <= 1'b0;
        end else if (bus.abort) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        // A zero step would stall forever, so it runs as 1.
                        step_lat  <= (bus.step_in == '0) ? STEP_W'(1) : bus.step_in;
                        upper_lat <= bus.upper_lim;
                        lower_lat <= bus.lower_lim;
                        err_flag  <= 1'b0;
                        state     <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    if (upper_lat < lower_lat) begin
                        err_flag <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        state <= ST_UP;
                    end
                end
                ST_UP: begin
                    if (!up_ok) begin
                        state <= ST_DOWN;
                    end
                end
                ST_DOWN: begin
                    if (!dn_ok) begin
`ifdef AUTO_RELOAD_EN
                        state <= ST_UP;
`else
                        state <= ST_DONE;
`endif
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_CLR) || (state == ST_UP) || (state == ST_DOWN);

    // Counter pins and status decode from the current state and lookahead compares.
    always_comb begin
        bus.cnt_enable  = 1'b0;
        bus.cnt_clear_n = (state != ST_CLR);
        bus.cnt_dir     = (state != ST_DOWN);
        bus.cnt_step    = busy ? step_lat : '0;
        bus.cnt_disp    = busy || (state == ST_DONE);
        bus.busy        = busy;
        bus.done        = (state == ST_DONE);
        bus.err         = err_flag;
        if (!bus.abort && !bus.hold) begin
            if (state == ST_UP) begin
                bus.cnt_enable = up_ok;
            end else if (state == ST_DOWN) begin
                bus.cnt_enable = dn_ok;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_sequencer
//  Brief    : Directed bench for counter_sequencer with a behavioural
//             16-bit up/down step counter on its control pins.
//  Revision : 1.0  initial release
// ============================================================================
module tb_counter_sequencer;
    import counter_seq_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    counter_sequencer_if #(.CNT_W(16), .STEP_W(5), .LAP_W(8)) sif ();

    counter_sequencer #(.CNT_W(16), .STEP_W(5), .LAP_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sif)
    );

    // Behavioural counter: sync active-low clear, enable, dir, step; not reset.
    logic [15:0] cnt_value = 16'd0;
    always @(posedge clock) begin
        if (!sif.cnt_clear_n)   cnt_value <= 16'd0;
        else if (sif.cnt_enable) cnt_value <= sif.cnt_dir ? cnt_value + 16'(sif.cnt_step)
                                                          : cnt_value - 16'(sif.cnt_step);
    end
    assign sif.count_value = cnt_value;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Per-sequence observations.
    int peak, final_v, err_v, step_seen, dones, ens, viol, clr_seen;

    task automatic run_seq(input logic [4:0] st, input logic [15:0] up, input logic [15:0] lo);
        bit seen;
        peak = 0; final_v = -1; err_v = -1; step_seen = 0;
        dones = 0; ens = 0; viol = 0; seen = 0;
        @(negedge clock);
        sif.step_in = st; sif.upper_lim = up; sif.lower_lim = lo; sif.start = 1'b1;
        @(negedge clock);
        sif.start = 1'b0;
        clr_seen = int'(!sif.cnt_clear_n);
        for (int cyc = 0; cyc < 400 && !seen; cyc++) begin
            if (sif.busy) step_seen = int'(sif.cnt_step);
            if (sif.cnt_clear_n && int'(cnt_value) > peak) peak = int'(cnt_value);
            if (sif.cnt_enable) begin
                ens++;
                if (sif.cnt_dir && (int'(cnt_value) + int'(sif.cnt_step) > int'(up))) viol++;
                if (!sif.cnt_dir && (int'(cnt_value) < int'(lo) + int'(sif.cnt_step))) viol++;
            end
            if (sif.done) begin
                dones++; seen = 1; final_v = int'(cnt_value); err_v = int'(sif.err);
            end else begin
                @(negedge clock);
            end
        end
        if (!seen) viol += 1000;
        @(negedge clock);
        if (sif.done) dones++;
        if (sif.busy) viol += 100;
    endtask

    typedef struct {
        logic [4:0]  step;
        logic [15:0] upper;
        logic [15:0] lower;
        int exp_peak;
        int exp_final;
        int exp_err;
        int exp_step;
        int exp_ens;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{5'd2, 16'd10, 16'd0, 10, 0, 0, 2, 10};
        vecs[1] = '{5'd3, 16'd10, 16'd1,  9, 3, 0, 3,  5};
        vecs[2] = '{5'd0, 16'd4,  16'd0,  4, 0, 0, 1,  8};
        vecs[3] = '{5'd4, 16'd4,  16'd0,  4, 0, 0, 4,  2};
        vecs[4] = '{5'd7, 16'd20, 16'd5, 14, 7, 0, 7,  3};
        vecs[5] = '{5'd2, 16'd5,  16'd9,  0, 0, 1, 2,  0};

        sif.start = 1'b0; sif.abort = 1'b0; sif.hold = 1'b0;
        sif.step_in = '0; sif.upper_lim = '0; sif.lower_lim = '0;

        // Reset state.
        #12;
        check("reset_outputs",
              int'({sif.cnt_enable, sif.cnt_clear_n, sif.cnt_dir, sif.cnt_step,
                    sif.cnt_disp, sif.busy, sif.done}), int'(11'b0_1_1_00000_0_0_0));
        check("reset_err", int'(sif.err), 0);
        check("reset_laps", int'(sif.laps), 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);

`ifndef AUTO_RELOAD_EN
        // Table of full sequences.
        for (int i = 0; i < 6; i++) begin
            run_seq(vecs[i].step, vecs[i].upper, vecs[i].lower);
            check($sformatf("v%0d_clr", i),   clr_seen, 1);
            check($sformatf("v%0d_peak", i),  peak, vecs[i].exp_peak);
            check($sformatf("v%0d_final", i), final_v, vecs[i].exp_final);
            check($sformatf("v%0d_err", i),   err_v, vecs[i].exp_err);
            check($sformatf("v%0d_step", i),  step_seen, vecs[i].exp_step);
            check($sformatf("v%0d_ens", i),   ens, vecs[i].exp_ens);
            check($sformatf("v%0d_dones", i), dones, 1);
            check($sformatf("v%0d_limits", i), viol, 0);
        end

        // Error flag stays set while idle.
        repeat (3) @(negedge clock);
        check("err_sticky", int'(sif.err), 1);
        check("laps_tied", int'(sif.laps), 0);
`endif

        // Hold mid-UP at value 6, then abort there.
        begin
            bit hit = 0;
            @(negedge clock);
            sif.step_in = 5'd2; sif.upper_lim = 16'd20; sif.lower_lim = 16'd0; sif.start = 1'b1;
            @(negedge clock);
            sif.start = 1'b0;
            check("start_clears_err", int'(sif.err), 0);
            for (int c = 0; c < 50 && !hit; c++) begin
                if (sif.busy && sif.cnt_dir && sif.cnt_clear_n && cnt_value == 16'd6) hit = 1;
                else @(negedge clock);
            end
            check("hold_reach6", int'(hit), 1);
            sif.hold = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(negedge clock);
                check("hold_frozen", int'({sif.busy, sif.cnt_dir, sif.cnt_enable, cnt_value}),
                      int'({1'b1, 1'b1, 1'b0, 16'd6}));
            end
            sif.hold = 1'b0; sif.abort = 1'b1;
            #1 check("abort_enable", int'(sif.cnt_enable), 0);
            @(negedge clock);
            sif.abort = 1'b0;
            check("abort_idle", int'({sif.busy, sif.cnt_disp, cnt_value}), int'({1'b0, 1'b0, 16'd6}));
        end

        // start and abort together in IDLE: abort wins.
        @(negedge clock);
        sif.start = 1'b1; sif.abort = 1'b1;
        @(negedge clock);
        sif.start = 1'b0; sif.abort = 1'b0;
        check("start_abort_idle", int'({sif.busy, sif.cnt_clear_n}), int'(2'b01));

`ifndef AUTO_RELOAD_EN
        // Asynchronous reset mid-DOWN.
        begin
            bit hit = 0;
            @(negedge clock);
            sif.step_in = 5'd2; sif.upper_lim = 16'd10; sif.lower_lim = 16'd0; sif.start = 1'b1;
            @(negedge clock);
            sif.start = 1'b0;
            for (int c = 0; c < 60 && !hit; c++) begin
                if (sif.busy && !sif.cnt_dir && cnt_value == 16'd6) hit = 1;
                else @(negedge clock);
            end
            check("down_reach6", int'(hit), 1);
            #1 reset = 1'b1;
            #1 check("async_reset_outputs",
                     int'({sif.cnt_enable, sif.cnt_clear_n, sif.cnt_dir, sif.cnt_step,
                           sif.cnt_disp, sif.busy, sif.done}), int'(11'b0_1_1_00000_0_0_0));
            @(negedge clock);
            reset = 1'b0;
            @(negedge clock);
            check("reset_keeps_value", int'({sif.busy, cnt_value}), int'({1'b0, 16'd6}));
        end
`else
        // Auto reload: laps count on each DOWN->UP, no done pulse.
        begin
            int nd = 0;
            bit hit = 0;
            @(negedge clock);
            sif.step_in = 5'd5; sif.upper_lim = 16'd20; sif.lower_lim = 16'd0; sif.start = 1'b1;
            @(negedge clock);
            sif.start = 1'b0;
            for (int c = 0; c < 200 && !hit; c++) begin
                if (sif.done) nd++;
                if (sif.laps == 8'd3) hit = 1;
                else @(negedge clock);
            end
            check("reload_3laps", int'(hit), 1);
            check("reload_no_done", nd, 0);
            check("reload_busy", int'(sif.busy), 1);
            sif.abort = 1'b1;
            @(negedge clock);
            sif.abort = 1'b0;
            check("reload_abort", int'({sif.busy, sif.laps}), int'({1'b0, 8'd3}));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
